game_io_regs: RTL and testbench
===============================

Name: game_io_regs

Overview:
- Parametrised memory-mapped game I/O bank. It is the successor to the fixed two-register ball_x/ball_y regfile tap.
- It sits on the processor's dmem bus beside RAM and holds NUM_OBJ object coordinate pairs, a control register, a status register and a winner register.
- Committed (display) coordinates update only on a frame boundary, which gives the VGA renderer tear-free double buffering.
- It reloads initial positions on reset or on a software restart.

Parameters:
- NUM_OBJ, 3, number of objects (ball, left paddle, right paddle); each object has an x and a y register.
- COORD_W, 10, coordinate width in bits.
- ADDR_W, 12, dmem address width.
- BASE_ADDR, 12'hF00, first word address of the bank.
- X_MAX, 639, x saturation limit.
- Y_MAX, 479, y saturation limit.
- AUTO_COMMIT, 1, commit mode: 1 = commit on every frame edge; 0 = commit only on a frame edge after software sets the commit request.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wren  in  1  dmem write enable from the processor.
- address_dmem  in  ADDR_W  dmem word address.
- data  in  32  dmem write data.
- q_io  out  32  registered read data.
- io_hit  out  1  registered; high when the previous-cycle address fell in the bank. The wrapper uses it to mux q_io over the RAM output.
- screen_end  in  1  end-of-frame level from the VGA controller, synchronous to clock.
- obj_init  in  NUM_OBJ*2*COORD_W  initial coordinates, packed {y,x} per object, object 0 in the LSBs.
- obj_disp  out  NUM_OBJ*2*COORD_W  committed coordinates, same packing.
- winner  out  2  winner code (0 none, 1 left, 2 right, 3 reserved).
- frame_pulse  out  1  one-cycle pulse on the detected frame edge.

Behaviour:
- Address map, as word offsets from BASE_ADDR:
  - Offset 2k is object k x; offset 2k+1 is object k y.
  - CTRL is at 2*NUM_OBJ: bit0 commit_req, bit1 restart, write-only self-clearing. Bit0 reads back as pending.
  - STATUS is at 2*NUM_OBJ+1: bit0 frame_flag (write 1 to clear), bits[31:16] frame_count (read-only).
  - WINNER is at 2*NUM_OBJ+2: bits[1:0], read/write.
  - Addresses above the map inside the decoded window read 0 and ignore writes.
- Decode: the bank is selected when address_dmem is in [BASE_ADDR, BASE_ADDR+2*NUM_OBJ+3).
- Read: q_io and io_hit are registered with 1-cycle latency. Non-selected cycles give q_io = 0 and io_hit = 0.
- Write: takes effect on the same clock edge that wren is sampled high.
  - Coordinate writes take data as an unsigned value and saturate: x = min(data, X_MAX), y = min(data, Y_MAX).
  - A data value whose bits 31:COORD_W are nonzero saturates to the limit.
- Frame edge: screen_end is registered once; the edge is screen_end & ~screen_end_q.
  - frame_pulse is high for that cycle.
  - frame_flag is set.
  - frame_count increments, wrapping 16'hFFFF -> 0.
- Commit, on a frame-edge cycle:
  - If AUTO_COMMIT=1 or the commit_req pending flag is set, obj_disp is loaded from the working registers and pending is cleared.
  - If AUTO_COMMIT=0 and nothing is pending, obj_disp holds.
- Simultaneous events:
  - A CPU coordinate write and a commit on the same edge: the commit captures the pre-write value; the new value appears at the next commit.
  - A commit_req write on a frame-edge cycle is not applied to that edge; it stays pending for the next one.
  - A frame_flag W1C on a frame-edge cycle: the set wins and the flag stays 1.
  - A restart and a frame edge together: the commit takes the pre-restart working values, and the working registers load obj_init.
- Restart: the working registers load obj_init, winner goes to 0 and pending is cleared. obj_disp changes only at the next commit, and frame_count is unaffected.
- Reset (reset=0, asynchronous):
  - Working and display registers load obj_init, saturated.
  - winner, frame_count, frame_flag, pending, q_io, io_hit, frame_pulse and screen_end_q all go to 0.
  - Reset asserted mid-frame discards any pending commit.
- Internal state: a two-state commit FSM, IDLE and PENDING, per mode. IDLE->PENDING on a commit_req write; PENDING->IDLE on a frame edge or a restart. With AUTO_COMMIT=1 it stays in IDLE.

Decomposition:
- Shared package game_io_pkg:
  - offset constants OFF_CTRL, OFF_STATUS, OFF_WINNER as functions of NUM_OBJ;
  - CTRL/STATUS bit positions;
  - winner codes WIN_NONE, WIN_LEFT, WIN_RIGHT.
- One sub-module, game_coord_reg: a single saturating working register plus display register with write, restart and commit enables. It is instantiated 2*NUM_OBJ times.

Test Plan:
- Reset with obj_init {x0=320,y0=240}: obj_disp object 0 = 320/240; STATUS reads 0; io_hit=0.
- Write 700 to x0 and 500 to y0 (AUTO_COMMIT=1), then pulse screen_end: the working x0 reads 639 and y0 reads 479 one cycle after the read address; obj_disp updates only on the frame_pulse cycle.
- AUTO_COMMIT=0: write x0=100 with no commit_req, run 3 frames -> obj_disp x0 unchanged. Write CTRL=1 -> obj_disp x0=100 at the next frame edge only; CTRL bit0 reads back 0 afterwards.
- Write x1 on the same edge as a frame edge -> obj_disp x1 keeps the old value; the new value appears after the next frame edge.
- Write WINNER=2, then CTRL=2 (restart) -> winner=0, working registers equal obj_init, obj_disp unchanged until the next frame; frame_count continues.
- Drive 65537 frame edges -> frame_count=1. W1C STATUS bit0 coincident with a frame edge -> frame_flag stays 1. Assert reset mid-frame -> all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/game_io_pkg.sv
// Shared register-map offsets, bit positions and codes for the game I/O bank.
// Pure constants and helpers; no logic, no timing.
package game_io_pkg;

  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_RESTART_BIT = 1;
  localparam int STAT_FLAG_BIT    = 0;
  localparam int STAT_CNT_LSB     = 16;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_LEFT  = 2'd1;
  localparam logic [1:0] WIN_RIGHT = 2'd2;

  typedef enum logic {
    CS_IDLE,
    CS_PENDING
  } commit_state_e;

  // Coordinate registers occupy the first 2*num_obj words; control words follow.
  function automatic int off_ctrl(input int num_obj);
    return 2 * num_obj;
  endfunction

  function automatic int off_status(input int num_obj);
    return 2 * num_obj + 1;
  endfunction

  function automatic int off_winner(input int num_obj);
    return 2 * num_obj + 2;
  endfunction

  function automatic int map_words(input int num_obj);
    return 2 * num_obj + 3;
  endfunction

endpackage

// File: rtl/game_coord_reg.sv
// One saturating coordinate: CPU-writable working copy plus frame-committed display copy.
// Writes, restart and commit all take effect on the sampling edge; never stalls.
module game_coord_reg
  import game_io_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int MAX_VAL = 639
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] init_val,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  input  logic               restart,
  input  logic               commit,
  output logic [COORD_W-1:0] work_val,
  output logic [COORD_W-1:0] disp_val
);

  logic [COORD_W-1:0] work_q, work_d;
  logic [COORD_W-1:0] disp_q, disp_d;
  logic [COORD_W-1:0] init_sat, wr_sat;

  always_comb begin
    init_sat = (32'(init_val) > 32'(MAX_VAL)) ? COORD_W'(MAX_VAL) : init_val;
    // Full 32-bit compare so any set upper bit clamps to the limit.
    wr_sat   = (wr_data > 32'(MAX_VAL)) ? COORD_W'(MAX_VAL) : wr_data[COORD_W-1:0];

    work_d = work_q;
    if (restart) begin
      work_d = init_sat;
    end else if (wr_en) begin
      work_d = wr_sat;
    end

    // Display copy takes the value held before this edge's write/restart.
    disp_d = commit ? work_q : disp_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work_q <= init_sat;
      disp_q <= init_sat;
    end else begin
      work_q <= work_d;
      disp_q <= disp_d;
    end
  end

  assign work_val = work_q;
  assign disp_val = disp_q;

endmodule

// File: rtl/game_io_regs.sv
// Memory-mapped game I/O bank: object coordinates double-buffered on frame edges, ctrl/status/winner.
// Reads return one cycle after the address; writes land on the sampling edge; no backpressure.
module game_io_regs
  import game_io_pkg::*;
#(
  parameter int                NUM_OBJ     = 3,
  parameter int                COORD_W     = 10,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'hF00,
  parameter int                X_MAX       = 639,
  parameter int                Y_MAX       = 479,
  parameter int                AUTO_COMMIT = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wren,
  input  logic [ADDR_W-1:0]            address_dmem,
  input  logic [31:0]                  data,
  output logic [31:0]                  q_io,
  output logic                         io_hit,
  input  logic                         screen_end,
  input  logic [NUM_OBJ*2*COORD_W-1:0] obj_init,
  output logic [NUM_OBJ*2*COORD_W-1:0] obj_disp,
  output logic [1:0]                   winner,
  output logic                         frame_pulse
);

  localparam int                NUM_REG    = 2 * NUM_OBJ;
  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(off_ctrl(NUM_OBJ));
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(off_status(NUM_OBJ));
  localparam logic [ADDR_W-1:0] OFF_WINNER = ADDR_W'(off_winner(NUM_OBJ));
  localparam logic [ADDR_W-1:0] END_ADDR   = BASE_ADDR + ADDR_W'(map_words(NUM_OBJ));

  logic                         sel, wr_sel;
  logic [ADDR_W-1:0]            off;
  logic                         frame_edge, commit, restart, commit_wr;
  logic [NUM_REG-1:0]           coord_wr;
  logic [NUM_OBJ*2*COORD_W-1:0] work_bus;

  commit_state_e state_q;
  logic          screen_end_q;
  logic          frame_pulse_q;
  logic          frame_flag_q, frame_flag_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [1:0]    winner_q, winner_d;
  logic [31:0]   q_io_q, q_io_d;
  logic          io_hit_q;

  always_comb begin
    sel        = (address_dmem >= BASE_ADDR) && (address_dmem < END_ADDR);
    off        = address_dmem - BASE_ADDR;
    wr_sel     = wren && sel;
    restart    = wr_sel && (off == OFF_CTRL) && data[CTRL_RESTART_BIT];
    commit_wr  = wr_sel && (off == OFF_CTRL) && data[CTRL_COMMIT_BIT];
    frame_edge = screen_end && !screen_end_q;
    commit     = frame_edge && ((AUTO_COMMIT != 0) || (state_q == CS_PENDING));
  end

  for (genvar i = 0; i < NUM_REG; i++) begin : g_coord
    localparam int MAXV = (i % 2 == 0) ? X_MAX : Y_MAX;

    assign coord_wr[i] = wr_sel && (off == ADDR_W'(i));

    game_coord_reg #(
      .COORD_W (COORD_W),
      .MAX_VAL (MAXV)
    ) u_reg (
      .clock    (clock),
      .reset    (reset),
      .init_val (obj_init[i*COORD_W +: COORD_W]),
      .wr_en    (coord_wr[i]),
      .wr_data  (data),
      .restart  (restart),
      .commit   (commit),
      .work_val (work_bus[i*COORD_W +: COORD_W]),
      .disp_val (obj_disp[i*COORD_W +: COORD_W])
    );
  end

  // A commit_req arriving on a frame edge outranks that edge's clear, so it waits for the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CS_IDLE;
    end else if (AUTO_COMMIT != 0) begin
      state_q <= CS_IDLE;
    end else if (restart) begin
      state_q <= CS_IDLE;
    end else if (commit_wr) begin
      state_q <= CS_PENDING;
    end else if (frame_edge) begin
      state_q <= CS_IDLE;
    end
  end

  always_comb begin
    frame_flag_d = frame_flag_q;
    if (frame_edge) begin
      frame_flag_d = 1'b1;
    end else if (wr_sel && (off == OFF_STATUS) && data[STAT_FLAG_BIT]) begin
      frame_flag_d = 1'b0;
    end

    frame_count_d = frame_count_q + {15'd0, frame_edge};

    winner_d = winner_q;
    if (restart) begin
      winner_d = WIN_NONE;
    end else if (wr_sel && (off == OFF_WINNER)) begin
      winner_d = data[1:0];
    end

    q_io_d = '0;
    if (sel) begin
      for (int i = 0; i < NUM_REG; i++) begin
        if (off == ADDR_W'(i)) begin
          q_io_d = 32'(work_bus[i*COORD_W +: COORD_W]);
        end
      end
      if (off == OFF_CTRL) begin
        q_io_d[CTRL_COMMIT_BIT] = (state_q == CS_PENDING);
      end
      if (off == OFF_STATUS) begin
        q_io_d[STAT_FLAG_BIT]         = frame_flag_q;
        q_io_d[STAT_CNT_LSB +: 16]    = frame_count_q;
      end
      if (off == OFF_WINNER) begin
        q_io_d[1:0] = winner_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      screen_end_q  <= 1'b0;
      frame_pulse_q <= 1'b0;
      frame_flag_q  <= 1'b0;
      frame_count_q <= 16'd0;
      winner_q      <= WIN_NONE;
      q_io_q        <= 32'd0;
      io_hit_q      <= 1'b0;
    end else begin
      screen_end_q  <= screen_end;
      frame_pulse_q <= frame_edge;
      frame_flag_q  <= frame_flag_d;
      frame_count_q <= frame_count_d;
      winner_q      <= winner_d;
      q_io_q        <= q_io_d;
      io_hit_q      <= sel;
    end
  end

  assign q_io        = q_io_q;
  assign io_hit      = io_hit_q;
  assign winner      = winner_q;
  assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_game_io_regs.sv
// Directed bench: one auto-commit and one manual-commit bank share the same bus and frame stimulus.
// Each task drives its scenario and checks against hand-computed values.
module tb_game_io_regs;
  import game_io_pkg::*;

  localparam logic [59:0] INIT = {10'd200, 10'd630, 10'd200, 10'd10, 10'd240, 10'd320};
  localparam logic [11:0] A_X0 = 12'hF00, A_Y0 = 12'hF01, A_X1 = 12'hF02;
  localparam logic [11:0] A_CTRL = 12'hF06, A_STAT = 12'hF07, A_WIN = 12'hF08;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren = 1'b0;
  logic [11:0] address = 12'h000;
  logic [31:0] data = 32'd0;
  logic        screen_end = 1'b0;
  logic [59:0] obj_init = INIT;

  logic [31:0] q_io_a, q_io_m;
  logic        hit_a, hit_m, fp_a, fp_m;
  logic [59:0] disp_a, disp_m;
  logic [1:0]  winner_a, winner_m;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clock = ~clock;

  game_io_regs #(.AUTO_COMMIT(1)) u_auto (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address), .data(data),
    .q_io(q_io_a), .io_hit(hit_a), .screen_end(screen_end), .obj_init(obj_init),
    .obj_disp(disp_a), .winner(winner_a), .frame_pulse(fp_a)
  );

  game_io_regs #(.AUTO_COMMIT(0)) u_man (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address), .data(data),
    .q_io(q_io_m), .io_hit(hit_m), .screen_end(screen_end), .obj_init(obj_init),
    .obj_disp(disp_m), .winner(winner_m), .frame_pulse(fp_m)
  );

  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock); wren = 1'b1; address = a; data = d;
    @(negedge clock); wren = 1'b0; address = 12'h000; data = 32'd0;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [31:0] qa, output logic [31:0] qm,
                          output logic ha);
    @(negedge clock); wren = 1'b0; address = a;
    @(posedge clock); #1;
    qa = q_io_a; qm = q_io_m; ha = hit_a;
  endtask

  task automatic frame();
    @(negedge clock); screen_end = 1'b1;
    @(negedge clock); screen_end = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    logic [31:0] qa, qm; logic ha;
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    tests++; if (disp_a[9:0] !== 10'd320) begin fails++; $display("FAIL rst_disp_x0 got %0d exp 320", disp_a[9:0]); end
    tests++; if (disp_a[19:10] !== 10'd240) begin fails++; $display("FAIL rst_disp_y0 got %0d exp 240", disp_a[19:10]); end
    tests++; if (disp_m !== INIT) begin fails++; $display("FAIL rst_disp_man got %h exp %h", disp_m, INIT); end
    tests++; if ({hit_a, hit_m, fp_a, fp_m, winner_a} !== 6'd0) begin fails++; $display("FAIL rst_outs got %b exp 0", {hit_a, hit_m, fp_a, fp_m, winner_a}); end
    @(negedge clock); reset = 1'b1;
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa !== 32'd0 || ha !== 1'b1) begin fails++; $display("FAIL rst_status got %h hit %b exp 0 hit 1", qa, ha); end
    cpu_read(A_X0, qa, qm, ha);
    tests++; if (qa !== 32'd320) begin fails++; $display("FAIL rst_work_x0 got %0d exp 320", qa); end
    cpu_read(12'hF09, qa, qm, ha);
    tests++; if (ha !== 1'b0 || qa !== 32'd0) begin fails++; $display("FAIL above_map hit %b q %h exp 0 0", ha, qa); end
    cpu_read(12'hEFF, qa, qm, ha);
    tests++; if (ha !== 1'b0 || qa !== 32'd0) begin fails++; $display("FAIL below_map hit %b q %h exp 0 0", ha, qa); end
  endtask

  task automatic test_saturate();
    logic [31:0] qa, qm; logic ha;
    cpu_write(A_X0, 32'd700);
    cpu_write(A_Y0, 32'd500);
    cpu_write(A_X1, 32'h0001_0005);
    cpu_read(A_X0, qa, qm, ha);
    tests++; if (qa !== 32'd639) begin fails++; $display("FAIL sat_x0 got %0d exp 639", qa); end
    cpu_read(A_Y0, qa, qm, ha);
    tests++; if (qa !== 32'd479) begin fails++; $display("FAIL sat_y0 got %0d exp 479", qa); end
    cpu_read(A_X1, qa, qm, ha);
    tests++; if (qa !== 32'd639) begin fails++; $display("FAIL sat_hibits got %0d exp 639", qa); end
    @(negedge clock); address = 12'h000; screen_end = 1'b1;
    tests++; if (disp_a[9:0] !== 10'd320 || fp_a !== 1'b0) begin fails++; $display("FAIL pre_edge disp %0d pulse %b exp 320 0", disp_a[9:0], fp_a); end
    @(posedge clock); #1;
    tests++; if (fp_a !== 1'b1 || disp_a[19:0] !== {10'd479, 10'd639}) begin fails++; $display("FAIL edge_commit pulse %b disp %h exp 1 %h", fp_a, disp_a[19:0], {10'd479, 10'd639}); end
    tests++; if (disp_m[9:0] !== 10'd320) begin fails++; $display("FAIL man_no_auto got %0d exp 320", disp_m[9:0]); end
    @(negedge clock); screen_end = 1'b0; exp_cnt++;
    @(posedge clock); #1;
    tests++; if (fp_a !== 1'b0) begin fails++; $display("FAIL pulse_width got %b exp 0", fp_a); end
  endtask

  task automatic test_manual_commit();
    logic [31:0] qa, qm; logic ha;
    cpu_write(A_X0, 32'd100);
    repeat (3) frame();
    tests++; if (disp_m[9:0] !== 10'd320) begin fails++; $display("FAIL man_hold got %0d exp 320", disp_m[9:0]); end
    tests++; if (disp_a[9:0] !== 10'd100) begin fails++; $display("FAIL auto_follow got %0d exp 100", disp_a[9:0]); end
    cpu_write(A_CTRL, 32'd1);
    cpu_read(A_CTRL, qa, qm, ha);
    tests++; if (qm !== 32'd1 || qa !== 32'd0) begin fails++; $display("FAIL pending_rd man %h auto %h exp 1 0", qm, qa); end
    tests++; if (disp_m[9:0] !== 10'd320) begin fails++; $display("FAIL man_wait got %0d exp 320", disp_m[9:0]); end
    frame();
    tests++; if (disp_m[29:0] !== {10'd639, 10'd479, 10'd100}) begin fails++; $display("FAIL man_commit got %h exp %h", disp_m[29:0], {10'd639, 10'd479, 10'd100}); end
    cpu_read(A_CTRL, qa, qm, ha);
    tests++; if (qm !== 32'd0) begin fails++; $display("FAIL pending_clr got %h exp 0", qm); end
  endtask

  task automatic test_ctrl_on_edge();
    logic [31:0] qa, qm; logic ha;
    cpu_write(A_X0, 32'd200);
    @(negedge clock); screen_end = 1'b1; wren = 1'b1; address = A_CTRL; data = 32'd1;
    @(negedge clock); screen_end = 1'b0; wren = 1'b0; address = 12'h000; data = 32'd0; exp_cnt++;
    tests++; if (disp_m[9:0] !== 10'd100) begin fails++; $display("FAIL req_on_edge got %0d exp 100", disp_m[9:0]); end
    cpu_read(A_CTRL, qa, qm, ha);
    tests++; if (qm !== 32'd1) begin fails++; $display("FAIL req_kept got %h exp 1", qm); end
    frame();
    tests++; if (disp_m[9:0] !== 10'd200) begin fails++; $display("FAIL req_next_edge got %0d exp 200", disp_m[9:0]); end
  endtask

  task automatic test_write_on_edge();
    logic [31:0] qa, qm; logic ha;
    @(negedge clock); screen_end = 1'b1; wren = 1'b1; address = A_X1; data = 32'd123;
    @(posedge clock); #1;
    tests++; if (disp_a[29:20] !== 10'd639) begin fails++; $display("FAIL wr_on_edge got %0d exp 639", disp_a[29:20]); end
    @(negedge clock); screen_end = 1'b0; wren = 1'b0; address = 12'h000; data = 32'd0; exp_cnt++;
    cpu_read(A_X1, qa, qm, ha);
    tests++; if (qa !== 32'd123) begin fails++; $display("FAIL wr_on_edge_work got %0d exp 123", qa); end
    frame();
    tests++; if (disp_a[29:20] !== 10'd123) begin fails++; $display("FAIL wr_next_commit got %0d exp 123", disp_a[29:20]); end
  endtask

  task automatic test_restart();
    logic [31:0] qa, qm; logic ha;
    logic [59:0] pre;
    pre = {10'd200, 10'd630, 10'd200, 10'd123, 10'd479, 10'd200};
    cpu_write(A_WIN, 32'(WIN_LEFT));
    tests++; if (winner_a !== 2'd1) begin fails++; $display("FAIL win_left got %0d exp 1", winner_a); end
    cpu_write(A_WIN, 32'(WIN_RIGHT));
    cpu_read(A_WIN, qa, qm, ha);
    tests++; if (qa !== 32'd2 || winner_a !== 2'd2) begin fails++; $display("FAIL win_right rd %h out %0d exp 2", qa, winner_a); end
    tests++; if (disp_a !== pre) begin fails++; $display("FAIL pre_restart_disp got %h exp %h", disp_a, pre); end
    cpu_write(A_CTRL, 32'd2);
    tests++; if (winner_a !== 2'd0 || winner_m !== 2'd0) begin fails++; $display("FAIL restart_win got %0d/%0d exp 0", winner_a, winner_m); end
    cpu_read(A_X0, qa, qm, ha);
    tests++; if (qa !== 32'd320) begin fails++; $display("FAIL restart_x0 got %0d exp 320", qa); end
    cpu_read(A_X1, qa, qm, ha);
    tests++; if (qa !== 32'd10) begin fails++; $display("FAIL restart_x1 got %0d exp 10", qa); end
    tests++; if (disp_a !== pre) begin fails++; $display("FAIL restart_disp_hold got %h exp %h", disp_a, pre); end
    frame();
    tests++; if (disp_a !== INIT) begin fails++; $display("FAIL restart_commit got %h exp %h", disp_a, INIT); end
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa[31:16] !== exp_cnt) begin fails++; $display("FAIL restart_count got %0d exp %0d", qa[31:16], exp_cnt); end
  endtask

  task automatic test_flag_and_wrap();
    logic [31:0] qa, qm; logic ha;
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa[0] !== 1'b1) begin fails++; $display("FAIL flag_set got %b exp 1", qa[0]); end
    cpu_write(A_STAT, 32'd1);
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa[0] !== 1'b0) begin fails++; $display("FAIL flag_w1c got %b exp 0", qa[0]); end
    @(negedge clock); screen_end = 1'b1; wren = 1'b1; address = A_STAT; data = 32'd1;
    @(negedge clock); screen_end = 1'b0; wren = 1'b0; address = 12'h000; data = 32'd0; exp_cnt++;
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa[0] !== 1'b1) begin fails++; $display("FAIL flag_set_wins got %b exp 1", qa[0]); end
    // Jump the counter to its last value instead of clocking through 65535 frames.
    @(negedge clock);
    force u_auto.frame_count_q = 16'hFFFF;
    force u_man.frame_count_q = 16'hFFFF;
    @(posedge clock); #1;
    release u_auto.frame_count_q;
    release u_man.frame_count_q;
    frame();
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa[31:16] !== 16'h0000) begin fails++; $display("FAIL count_wrap got %h exp 0000", qa[31:16]); end
    frame();
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa[31:16] !== 16'h0001 || qm[31:16] !== 16'h0001) begin fails++; $display("FAIL count_after_wrap got %h/%h exp 0001", qa[31:16], qm[31:16]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] qa, qm; logic ha;
    cpu_write(A_WIN, 32'd3);
    cpu_write(A_X0, 32'd55);
    @(negedge clock); screen_end = 1'b1; wren = 1'b1; address = A_CTRL; data = 32'd1;
    @(posedge clock); #1;
    tests++; if (fp_a !== 1'b1 || hit_a !== 1'b1 || winner_a !== 2'd3) begin fails++; $display("FAIL pre_reset pulse %b hit %b win %0d exp 1 1 3", fp_a, hit_a, winner_a); end
    #2 reset = 1'b0;
    #1;
    tests++; if ({fp_a, hit_a, winner_a, winner_m} !== 6'd0 || q_io_a !== 32'd0) begin fails++; $display("FAIL async_rst outs %b q %h exp 0", {fp_a, hit_a, winner_a, winner_m}, q_io_a); end
    tests++; if (disp_a !== INIT || disp_m !== INIT) begin fails++; $display("FAIL async_rst_disp got %h/%h exp %h", disp_a, disp_m, INIT); end
    @(negedge clock); screen_end = 1'b0; wren = 1'b0; address = 12'h000; data = 32'd0; reset = 1'b1;
    exp_cnt = 16'd0;
    cpu_read(A_CTRL, qm, qa, ha);
    tests++; if (qa !== 32'd0) begin fails++; $display("FAIL rst_discard_pending got %h exp 0", qa); end
    cpu_read(A_STAT, qa, qm, ha);
    tests++; if (qa !== 32'd0) begin fails++; $display("FAIL rst_status2 got %h exp 0", qa); end
    cpu_read(A_X0, qa, qm, ha);
    tests++; if (qa !== 32'd320) begin fails++; $display("FAIL rst_work_reload got %0d exp 320", qa); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t exp completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_saturate();
    test_manual_commit();
    test_ctrl_on_edge();
    test_write_on_edge();
    test_restart();
    test_flag_and_wrap();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
